// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: fetches one-hot moves and issues a vertical
// then horizontal drive leg per move. Optional legality check: TOUR_MOVE_CHECK_EN.
module tour_cmd_seq #(
   parameter int         NUM_MOVES  = 24,
   parameter int         ADDR_W     = 6,
   parameter logic [3:0] FANFARE_OP = 4'h5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_tour,
   input  logic              abort,
   output logic [ADDR_W-1:0] mv_addr,
   input  logic [7:0]        mv_data,
   output logic [15:0]       cmd,
   output logic              cmd_rdy,
   input  logic              clr_cmd_rdy,
   input  logic              send_resp,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, VERT, WAIT_V, HORZ, WAIT_H
   } state_t;

   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_MOVES - 1);
   localparam logic [7:0]        HDG_N = 8'h00;
   localparam logic [7:0]        HDG_W = 8'h3F;
   localparam logic [7:0]        HDG_S = 8'h7F;
   localparam logic [7:0]        HDG_E = 8'hBF;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [7:0]        r_mv, w_mv_nxt;
   logic [15:0]       r_cmd, w_cmd_nxt;
   logic              r_rdy, w_rdy_nxt;
   logic              r_done, w_done_nxt;
   logic              w_err_nxt;

   logic [2:0]  w_idx;
   logic        w_dx_neg, w_dy_neg;
   logic [1:0]  w_dx_mag, w_dy_mag;
   logic [15:0] w_vcmd, w_hcmd;

   // Lowest set bit wins; an all-zero move falls through to move 0.
   always_comb begin
      w_idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (r_mv[i]) w_idx = 3'(i);
   end

   always_comb begin
      w_dx_neg = 1'b0; w_dx_mag = 2'd1;
      w_dy_neg = 1'b0; w_dy_mag = 2'd2;
      case (w_idx)
         3'd0: begin w_dx_neg = 1'b0; w_dx_mag = 2'd1; w_dy_neg = 1'b0; w_dy_mag = 2'd2; end
         3'd1: begin w_dx_neg = 1'b1; w_dx_mag = 2'd1; w_dy_neg = 1'b0; w_dy_mag = 2'd2; end
         3'd2: begin w_dx_neg = 1'b1; w_dx_mag = 2'd2; w_dy_neg = 1'b0; w_dy_mag = 2'd1; end
         3'd3: begin w_dx_neg = 1'b1; w_dx_mag = 2'd2; w_dy_neg = 1'b1; w_dy_mag = 2'd1; end
         3'd4: begin w_dx_neg = 1'b1; w_dx_mag = 2'd1; w_dy_neg = 1'b1; w_dy_mag = 2'd2; end
         3'd5: begin w_dx_neg = 1'b0; w_dx_mag = 2'd1; w_dy_neg = 1'b1; w_dy_mag = 2'd2; end
         3'd6: begin w_dx_neg = 1'b0; w_dx_mag = 2'd2; w_dy_neg = 1'b1; w_dy_mag = 2'd1; end
         default: begin w_dx_neg = 1'b0; w_dx_mag = 2'd2; w_dy_neg = 1'b0; w_dy_mag = 2'd1; end
      endcase
   end

   assign w_vcmd = {4'h4,       (w_dy_neg ? HDG_S : HDG_N), 2'b00, w_dy_mag};
   assign w_hcmd = {FANFARE_OP, (w_dx_neg ? HDG_W : HDG_E), 2'b00, w_dx_mag};

`ifdef TOUR_MOVE_CHECK_EN
   logic w_onehot;
   assign w_onehot = (mv_data != 8'd0) && ((mv_data & (mv_data - 8'd1)) == 8'd0);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_mv_nxt    = r_mv;
      w_cmd_nxt   = r_cmd;
      w_rdy_nxt   = r_rdy;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      if (abort) begin
         w_state_nxt = IDLE;
         w_rdy_nxt   = 1'b0;
         w_addr_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_tour) begin
                  w_state_nxt = FETCH;
                  w_addr_nxt  = '0;
               end
            end
            FETCH: w_state_nxt = DECODE;
            DECODE: begin
`ifdef TOUR_MOVE_CHECK_EN
               if (!w_onehot) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_mv_nxt    = mv_data;
                  w_state_nxt = VERT;
               end
`else
               w_mv_nxt    = mv_data;
               w_state_nxt = VERT;
`endif
            end
            // First cycle of a leg loads the command; clr is only honoured once it is up.
            VERT: begin
               if (!r_rdy) begin
                  w_cmd_nxt = w_vcmd;
                  w_rdy_nxt = 1'b1;
               end else if (clr_cmd_rdy) begin
                  w_rdy_nxt   = 1'b0;
                  w_state_nxt = WAIT_V;
               end
            end
            WAIT_V: if (send_resp) w_state_nxt = HORZ;
            HORZ: begin
               if (!r_rdy) begin
                  w_cmd_nxt = w_hcmd;
                  w_rdy_nxt = 1'b1;
               end else if (clr_cmd_rdy) begin
                  w_rdy_nxt   = 1'b0;
                  w_state_nxt = WAIT_H;
               end
            end
            WAIT_H: begin
               if (send_resp) begin
                  if (r_addr == LAST) begin
                     w_state_nxt = IDLE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_addr_nxt  = r_addr + 1'b1;
                     w_state_nxt = FETCH;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_mv    <= '0;
         r_cmd   <= 16'h0000;
         r_rdy   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_mv    <= w_mv_nxt;
         r_cmd   <= w_cmd_nxt;
         r_rdy   <= w_rdy_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef TOUR_MOVE_CHECK_EN
   logic r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_err_nxt;
   end
   assign err = r_err;
`else
   logic w_err_unused;
   assign w_err_unused = w_err_nxt;
   assign err = 1'b0;
`endif

   assign mv_addr = r_addr;
   assign cmd     = r_cmd;
   assign cmd_rdy = r_rdy;
   assign busy    = (r_state != IDLE);
   assign done    = r_done;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: random one-hot tours, directed boundary cases.
module tb_tour_cmd_seq;
   localparam int NM = 4;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_tour = 1'b0, abort = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
   logic [AW-1:0] mv_addr;
   logic [7:0]    mv_data;
   logic [15:0]   cmd;
   logic          cmd_rdy, busy, done, err;

   logic [7:0]  mem [0:63];
   logic [15:0] exp_q [$];
   int checks = 0, failures = 0;
   int done_cnt = 0, err_cnt = 0, exp_err = 0;
   logic prev_rdy = 1'b0;

   assign mv_data = mem[mv_addr];

   always #5 clk = ~clk;

   tour_cmd_seq #(.NUM_MOVES(NM), .ADDR_W(AW), .FANFARE_OP(4'h5)) dut (
      .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .abort(abort),
      .mv_addr(mv_addr), .mv_data(mv_data), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Reference model: knight move table straight from the move rules.
   function automatic int mvidx(input logic [7:0] m);
      for (int k = 0; k < 8; k++) if (m[k]) return k;
      return 0;
   endfunction

   function automatic void dxy(input int k, output int dx, output int dy);
      case (k)
         0: begin dx =  1; dy =  2; end
         1: begin dx = -1; dy =  2; end
         2: begin dx = -2; dy =  1; end
         3: begin dx = -2; dy = -1; end
         4: begin dx = -1; dy = -2; end
         5: begin dx =  1; dy = -2; end
         6: begin dx =  2; dy = -1; end
         default: begin dx = 2; dy = 1; end
      endcase
   endfunction

   function automatic logic [15:0] vcmd(input logic [7:0] m);
      int dx, dy;
      dxy(mvidx(m), dx, dy);
      return {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
   endfunction

   function automatic logic [15:0] hcmd(input logic [7:0] m);
      int dx, dy;
      dxy(mvidx(m), dx, dy);
      return {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
   endfunction

   // Monitor: every rising cmd_rdy consumes one scoreboard entry.
   initial forever begin
      @(negedge clk);
      if (cmd_rdy && !prev_rdy) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_cmd: got %h expected none", cmd);
         end else chk("cmd", cmd, exp_q.pop_front());
      end
      prev_rdy = cmd_rdy;
      if (done) done_cnt++;
      if (err) err_cnt++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic wait_rdy(input int lat, input string nm);
      int n = 0;
      while (!cmd_rdy && n < 30) begin tick; n++; end
      chk({nm, "_lat"}, n, lat);
   endtask

   task automatic leg(input logic [15:0] e, input int lat, input bit dual);
      exp_q.push_back(e);
      wait_rdy(lat, "leg");
      repeat ($urandom_range(0, 2)) tick;
      chk("rdy_hold", cmd_rdy, 1);
      clr_cmd_rdy = 1'b1;
      send_resp = dual;
      tick;
      clr_cmd_rdy = 1'b0;
      send_resp = 1'b0;
      chk("rdy_clr", cmd_rdy, 0);
      chk("cmd_kept", cmd, e);
      if (dual) begin
         tick; tick;
         chk("resp_not_latched", cmd_rdy, 0);
      end
   endtask

   task automatic resp;
      repeat ($urandom_range(0, 3)) tick;
      send_resp = 1'b1;
      tick;
      send_resp = 1'b0;
   endtask

   task automatic fill_rand;
      for (int i = 0; i < 64; i++) mem[i] = 8'h01 << $urandom_range(0, 7);
   endtask

   task automatic run_tour(input bit poke);
      int d0;
      chk("idle_busy", busy, 0);
      start_tour = 1'b1; tick; start_tour = 1'b0;
      chk("busy", busy, 1);
      chk("addr0", mv_addr, 0);
      d0 = done_cnt;
      for (int i = 0; i < NM; i++) begin
         leg(vcmd(mem[i]), 3, $urandom_range(0, 3) == 0);
         if (poke && i == NM - 2) begin
            start_tour = 1'b1; tick; start_tour = 1'b0;
            clr_cmd_rdy = 1'b1; tick; clr_cmd_rdy = 1'b0;
            chk("wv_rdy", cmd_rdy, 0);
            chk("wv_busy", busy, 1);
            chk("wv_cmd", cmd, vcmd(mem[i]));
            chk("wv_addr", mv_addr, i);
         end
         resp();
         leg(hcmd(mem[i]), 1, 1'b0);
         if (i == NM - 1) chk("addr_last", mv_addr, NM - 1);
         resp();
         if (i < NM - 1) chk("addr_inc", mv_addr, i + 1);
         else begin
            chk("done", done, 1);
            chk("busy_end", busy, 0);
         end
      end
      tick;
      chk("done_pulse", done, 0);
      chk("done_cnt", done_cnt - d0, 1);
   endtask

   task automatic bad_tour(input logic [7:0] b);
      fill_rand();
      mem[0] = b;
`ifdef TOUR_MOVE_CHECK_EN
      start_tour = 1'b1; tick; start_tour = 1'b0;
      tick; tick;
      chk("err_pulse", err, 1);
      chk("err_idle", busy, 0);
      tick;
      chk("err_clear", err, 0);
      chk("err_no_cmd", cmd_rdy, 0);
      exp_err++;
`else
      run_tour(1'b0);
`endif
   endtask

   initial begin
      int d0;
      fill_rand();
      #2;
      chk("rst_cmd", cmd, 16'h0000);
      chk("rst_rdy", cmd_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", mv_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      #10 rst_n = 1'b1;
      tick; tick;

      mem[0] = 8'h08; mem[1] = 8'h10; mem[2] = 8'h80; mem[3] = 8'h01;
      run_tour(1'b0);

      for (int t = 0; t < 6; t++) begin
         fill_rand();
         run_tour(t == 0 || t == 3);
      end

      bad_tour(8'h03);
      bad_tour(8'h00);

      // Abort with send_resp in WAIT_H of move 1.
      fill_rand();
      start_tour = 1'b1; tick; start_tour = 1'b0;
      leg(vcmd(mem[0]), 3, 1'b0); resp();
      leg(hcmd(mem[0]), 1, 1'b0); resp();
      leg(vcmd(mem[1]), 3, 1'b0); resp();
      leg(hcmd(mem[1]), 1, 1'b0);
      d0 = done_cnt;
      abort = 1'b1; send_resp = 1'b1; tick; abort = 1'b0; send_resp = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_rdy", cmd_rdy, 0);
      chk("abort_addr", mv_addr, 0);
      tick; tick;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_stays_idle", busy, 0);

      // Abort beats clr while a vertical command is pending.
      start_tour = 1'b1; tick; start_tour = 1'b0;
      exp_q.push_back(vcmd(mem[0]));
      wait_rdy(3, "abv");
      tick;
      abort = 1'b1; clr_cmd_rdy = 1'b1; tick; abort = 1'b0; clr_cmd_rdy = 1'b0;
      chk("abv_rdy", cmd_rdy, 0);
      chk("abv_busy", busy, 0);

      // Asynchronous reset while in VERT with cmd_rdy up.
      fill_rand();
      start_tour = 1'b1; tick; start_tour = 1'b0;
      exp_q.push_back(vcmd(mem[0]));
      wait_rdy(3, "rstv");
      tick;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cmd", cmd, 16'h0000);
      chk("arst_rdy", cmd_rdy, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", mv_addr, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err, 0);
      #3 rst_n = 1'b1;
      tick;
      send_resp = 1'b1; clr_cmd_rdy = 1'b1; tick; send_resp = 1'b0; clr_cmd_rdy = 1'b0;
      chk("idle_ignore", busy, 0);
      chk("idle_ignore_rdy", cmd_rdy, 0);

      fill_rand();
      run_tour(1'b1);

      repeat (3) tick;
      chk("queue_empty", exp_q.size(), 0);
      chk("err_count", err_cnt, exp_err);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
